// File: rtl/pattern_tx.sv
// Oversampled pattern transmitter: serialises a stored SAMPLES-bit pattern,
// holding each bit on Tx_Bit for OSF enabled clock cycles.
module pattern_tx #(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Wr_En,
  input  logic [$clog2(SAMPLES)-1:0] Wr_Addr,
  input  logic                       Wr_Data,
  input  logic                       Start,
  input  logic                       EN,
  output logic                       Tx_Bit,
  output logic                       Busy,
  output logic                       Sample_Strobe,
  output logic                       Last,
  output logic                       Done
);

  localparam int AW = $clog2(SAMPLES);
  localparam int PW = (OSF > 1) ? $clog2(OSF) : 1;
  localparam logic [AW-1:0] SLAST = AW'(SAMPLES - 1);
  localparam logic [PW-1:0] PLAST = PW'(OSF - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [SAMPLES-1:0] mem;
  logic [AW-1:0]   s;
  logic [PW-1:0]   p;
  logic [AW-1:0]   snext;
  logic            sampleEnd;
  logic            frameEnd;

  assign snext     = s + AW'(1);
  assign sampleEnd = (p == PLAST);
  assign frameEnd  = sampleEnd && (s == SLAST);

  assign Sample_Strobe = Busy && EN && (p == '0);
  assign Last          = Busy && EN && frameEnd;

  // Pattern storage survives reset and is frozen while a frame is running.
  always_ff @(posedge Clk) begin
    if (!Reset && state == IDLE && Wr_En) begin
      mem[Wr_Addr] <= Wr_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Tx_Bit <= 1'b0;
      s      <= '0;
      p      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= SEND;
            Busy  <= 1'b1;
            s     <= '0;
            p     <= '0;
            // A same-edge write to address 0 must reach the first sample.
            Tx_Bit <= (Wr_En && Wr_Addr == '0) ? Wr_Data : mem[0];
          end
        end
        SEND: begin
          if (EN) begin
            if (!sampleEnd) begin
              p <= p + PW'(1);
            end else if (!frameEnd) begin
              p      <= '0;
              s      <= snext;
              Tx_Bit <= mem[snext];
            end else begin
              state  <= IDLE;
              Busy   <= 1'b0;
              Done   <= 1'b1;
              Tx_Bit <= 1'b0;
              s      <= '0;
              p      <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: a small 4x2 instance checked cycle by
// cycle against a frame-level model, plus a default 128x8 instance.
module tb_pattern_tx;

  localparam int SAMPLES = 4;
  localparam int OSF     = 2;
  localparam int AW      = 2;
  localparam int FRAME   = SAMPLES * OSF;
  localparam int BAW     = 7;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset, Wr_En, Wr_Data, Start, EN;
  logic [AW-1:0] Wr_Addr;
  logic          Tx_Bit, Busy, Sample_Strobe, Last, Done;

  logic           bReset, bWrEn, bWrData, bStart, bEN;
  logic [BAW-1:0] bWrAddr;
  logic           bTx, bBusy, bStrobe, bLast, bDone;

  pattern_tx #(.SAMPLES(SAMPLES), .OSF(OSF)) dut (
    .Clk(Clk), .Reset(Reset), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr),
    .Wr_Data(Wr_Data), .Start(Start), .EN(EN), .Tx_Bit(Tx_Bit),
    .Busy(Busy), .Sample_Strobe(Sample_Strobe), .Last(Last), .Done(Done)
  );

  pattern_tx dutBig (
    .Clk(Clk), .Reset(bReset), .Wr_En(bWrEn), .Wr_Addr(bWrAddr),
    .Wr_Data(bWrData), .Start(bStart), .EN(bEN), .Tx_Bit(bTx),
    .Busy(bBusy), .Sample_Strobe(bStrobe), .Last(bLast), .Done(bDone)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the frame is a count k of enabled cycles, sample k/OSF.
  logic refMem [SAMPLES];
  logic mBusy = 1'b0, mDone = 1'b0, mTx = 1'b0;
  int   k = 0;
  bit   modelValid = 1'b0;

  int          cntBusy, cntActive, cntStrobe, cntLast, cntDone, doneAt;
  logic [31:0] txHist;
  bit          sawDone;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic modelStep(input logic rst, we, input logic [AW-1:0] wa, input logic wd, st, en);
    if (rst) begin
      mBusy = 1'b0; mDone = 1'b0; mTx = 1'b0; k = 0; modelValid = 1'b1;
    end else begin
      mDone = 1'b0;
      if (!mBusy) begin
        if (we) refMem[wa] = wd;
        if (st) begin
          mBusy = 1'b1; k = 0; mTx = refMem[0];
        end
      end else if (en) begin
        k++;
        if (k == FRAME) begin
          mBusy = 1'b0; mDone = 1'b1; mTx = 1'b0; k = 0;
        end else begin
          mTx = refMem[k / OSF];
        end
      end
    end
  endtask

  task automatic clearCounts();
    cntBusy = 0; cntActive = 0; cntStrobe = 0; cntLast = 0; cntDone = 0; txHist = '0;
  endtask

  task automatic applyStimulus(input logic rst, we, input logic [AW-1:0] wa, input logic wd, st, en);
    Reset = rst; Wr_En = we; Wr_Addr = wa; Wr_Data = wd; Start = st; EN = en;
    #1;
    if (modelValid) begin
      checkOutput("busy", Busy, mBusy);
      checkOutput("done", Done, mDone);
      checkOutput("tx", Tx_Bit, mTx);
      checkOutput("strobe", Sample_Strobe, mBusy && en && (k % OSF == 0));
      checkOutput("last", Last, mBusy && en && (k == FRAME - 1));
    end
    if (Busy === 1'b1) begin
      cntBusy++;
      txHist = {txHist[30:0], Tx_Bit};
      if (en) cntActive++;
    end
    if (Sample_Strobe === 1'b1) cntStrobe++;
    if (Last === 1'b1) cntLast++;
    sawDone = (Done === 1'b1);
    if (sawDone) cntDone++;
    @(posedge Clk);
    modelStep(rst, we, wa, wd, st, en);
    @(negedge Clk);
  endtask

  // Runs steps after a Start until Done is seen or the budget runs out.
  task automatic runFrame(input int maxSteps, gapFrom, gapTo, injectAt, resetAt, input bit startOnDone);
    logic en, rst, inj, st;
    doneAt = 0;
    for (int i = 1; i <= maxSteps; i++) begin
      en  = !(i >= gapFrom && i <= gapTo);
      rst = (i == resetAt);
      inj = (i == injectAt);
      st  = inj || (startOnDone && mDone);
      applyStimulus(rst, inj, AW'(2), 1'b0, st, en);
      if (sawDone) begin
        doneAt = i;
        break;
      end
    end
  endtask

  logic [SAMPLES-1:0] basicPat;
  int busyCnt, strobeCnt, rxCount, lastAt, bigDoneAt, sIdx;

  initial begin
    Reset = 1'b1; Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = 1'b0; Start = 1'b0; EN = 1'b0;
    bReset = 1'b1; bWrEn = 1'b0; bWrAddr = '0; bWrData = 1'b0; bStart = 1'b0; bEN = 1'b1;
    @(negedge Clk);

    // Reset, then Start under reset must be ignored.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    basicPat = 4'b1101;
    for (int a = 0; a < SAMPLES; a++)
      applyStimulus(1'b0, 1'b1, AW'(a), basicPat[a], 1'b0, 1'b1);

    clearCounts();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    runFrame(20, 100, 0, 0, 0, 1'b0);
    checkOutput("basic_done_at", doneAt, 9);
    checkOutput("basic_busy_cycles", cntBusy, 8);
    checkOutput("basic_strobes", cntStrobe, 4);
    checkOutput("basic_lasts", cntLast, 1);
    checkOutput("basic_tx_seq", txHist[7:0], 8'b11001111);

    clearCounts();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    runFrame(30, 2, 4, 0, 0, 1'b0);
    checkOutput("gap_done_at", doneAt, 12);
    checkOutput("gap_enabled_cycles", cntActive, 8);
    checkOutput("gap_busy_cycles", cntBusy, 11);
    checkOutput("gap_strobes", cntStrobe, 4);
    checkOutput("gap_tx_seq", txHist[10:0], 11'b11111001111);

    // Write and Start during Busy are ignored; Start in the Done cycle chains.
    clearCounts();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    runFrame(20, 100, 0, 3, 0, 1'b1);
    checkOutput("ignore_done_at", doneAt, 9);
    checkOutput("ignore_tx_seq", txHist[7:0], 8'b11001111);
    clearCounts();
    runFrame(20, 100, 0, 0, 0, 1'b0);
    checkOutput("chain_done_at", doneAt, 9);
    checkOutput("chain_busy_cycles", cntBusy, 8);
    checkOutput("chain_tx_seq", txHist[7:0], 8'b11001111);

    // Bypass write to address 0 at Start, then abort with reset in sample 2.
    clearCounts();
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1);
    runFrame(12, 100, 0, 0, 5, 1'b0);
    checkOutput("abort_done_at", doneAt, 0);
    checkOutput("abort_done_count", cntDone, 0);
    checkOutput("abort_busy_cycles", cntBusy, 5);
    checkOutput("abort_tx_seq", txHist[4:0], 5'b00001);
    clearCounts();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    runFrame(20, 100, 0, 0, 0, 1'b0);
    checkOutput("replay_done_at", doneAt, 9);
    checkOutput("replay_tx_seq", txHist[7:0], 8'b00001111);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                    AW'($urandom_range(0, SAMPLES - 1)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    end

    // Default 128x8 instance with an alternating pattern and EN held high.
    repeat (2) @(negedge Clk);
    bReset = 1'b0;
    for (int a = 0; a < 128; a++) begin
      bWrEn = 1'b1; bWrAddr = BAW'(a); bWrData = (a % 2 == 1);
      @(negedge Clk);
    end
    bWrEn = 1'b0; bStart = 1'b1;
    @(negedge Clk);
    bStart = 1'b0;
    busyCnt = 0; strobeCnt = 0; rxCount = 0; lastAt = 0; bigDoneAt = 0; sIdx = 0;
    for (int i = 1; i <= 1100 && bigDoneAt == 0; i++) begin
      #1;
      if (bBusy === 1'b1) busyCnt++;
      if (bBusy === 1'b1 && bEN) rxCount++;
      if (bStrobe === 1'b1) begin
        checkOutput("big_tx", bTx, sIdx % 2);
        sIdx++;
        strobeCnt++;
      end
      if (bLast === 1'b1) begin
        lastAt = i;
        checkOutput("big_rx_at_last", rxCount, 1024);
      end
      if (bDone === 1'b1) bigDoneAt = i;
      @(negedge Clk);
    end
    checkOutput("big_busy_cycles", busyCnt, 1024);
    checkOutput("big_strobes", strobeCnt, 128);
    checkOutput("big_last_at", lastAt, 1024);
    checkOutput("big_done_at", bigDoneAt, 1025);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
